// File: rtl/reg_read_issue.sv
`default_nettype none
// =====================================================================
// Module   : reg_read_issue
// Summary  : Operand-read and issue stage for the 32x32 register file.
//            Keeps a per-register busy scoreboard, checks RAW/WAW
//            hazards, reads rs1/rs2 from the flat register-file bus and
//            registers the instruction into a one-entry issue slot.
//            The four register-file write ports are snooped to clear
//            busy bits.
// Options  : REG_BYPASS_EN - when defined, same-cycle writeback data is
//            forwarded to the operands and a writeback hit counts as a
//            ready source. When undefined, a source is ready only once
//            its busy bit is clear.
// Revision : 1.0 - initial release
// =====================================================================
module reg_read_issue (
  input  logic          clk,
  input  logic          rst,
  input  logic [1023:0] reg_rdata_i,
  input  logic          we_jump_0_i,
  input  logic [4:0]    waddr_jump_0_i,
  input  logic [31:0]   wdata_jump_0_i,
  input  logic          we_mem_0_i,
  input  logic [4:0]    waddr_mem_0_i,
  input  logic [31:0]   wdata_mem_0_i,
  input  logic          we_int_0_i,
  input  logic [4:0]    waddr_int_0_i,
  input  logic [31:0]   wdata_int_0_i,
  input  logic          we_int_1_i,
  input  logic [4:0]    waddr_int_1_i,
  input  logic [31:0]   wdata_int_1_i,
  input  logic          dec_valid_i,
  output logic          dec_ready_o,
  input  logic [4:0]    dec_rs1_i,
  input  logic [4:0]    dec_rs2_i,
  input  logic          dec_rs1_use_i,
  input  logic          dec_rs2_use_i,
  input  logic [4:0]    dec_rd_i,
  input  logic          dec_rd_we_i,
  input  logic [31:0]   dec_info_i,
  input  logic          flush_i,
  output logic          iss_valid_o,
  input  logic          iss_ready_i,
  output logic [31:0]   iss_rs1_data_o,
  output logic [31:0]   iss_rs2_data_o,
  output logic [4:0]    iss_rd_o,
  output logic          iss_rd_we_o,
  output logic [31:0]   iss_info_o,
  output logic [31:0]   busy_o
);

  localparam logic [4:0] c_X0 = 5'd0;

  // Registered state
  logic [31:0] r_busy;
  logic        r_iss_valid;
  logic [31:0] r_iss_rs1_data;
  logic [31:0] r_iss_rs2_data;
  logic [4:0]  r_iss_rd;
  logic        r_iss_rd_we;
  logic [31:0] r_iss_info;

  // Combinational
  logic [31:0] w_wb_hit;
  logic [31:0] w_rs1_rf;
  logic [31:0] w_rs2_rf;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic        w_rs1_ready;
  logic        w_rs2_ready;
  logic        w_waw;
  logic        w_slot_free;
  logic        w_accept;
  logic [31:0] w_busy_next;

  // Decode which registers are being written back this cycle (x0 never hits)
  always_comb begin
    w_wb_hit = '0;
    for (int r = 1; r < 32; r++) begin
      w_wb_hit[r] = (we_jump_0_i && (waddr_jump_0_i == 5'(r))) ||
                    (we_mem_0_i  && (waddr_mem_0_i  == 5'(r))) ||
                    (we_int_0_i  && (waddr_int_0_i  == 5'(r))) ||
                    (we_int_1_i  && (waddr_int_1_i  == 5'(r)));
    end
  end

  // Register-file read of both sources from the flat contents bus
  assign w_rs1_rf = reg_rdata_i[{dec_rs1_i, 5'b00000} +: 32];
  assign w_rs2_rf = reg_rdata_i[{dec_rs2_i, 5'b00000} +: 32];

`ifdef REG_BYPASS_EN
  logic [31:0] w_rs1_byp;
  logic [31:0] w_rs2_byp;
  logic        w_rs1_hit;
  logic        w_rs2_hit;

  assign w_rs1_hit = w_wb_hit[dec_rs1_i];
  assign w_rs2_hit = w_wb_hit[dec_rs2_i];

  // Forwarded writeback data, same port priority as the register file
  always_comb begin
    if (we_jump_0_i && (waddr_jump_0_i == dec_rs1_i))     w_rs1_byp = wdata_jump_0_i;
    else if (we_mem_0_i && (waddr_mem_0_i == dec_rs1_i))  w_rs1_byp = wdata_mem_0_i;
    else if (we_int_0_i && (waddr_int_0_i == dec_rs1_i))  w_rs1_byp = wdata_int_0_i;
    else                                                  w_rs1_byp = wdata_int_1_i;
    if (we_jump_0_i && (waddr_jump_0_i == dec_rs2_i))     w_rs2_byp = wdata_jump_0_i;
    else if (we_mem_0_i && (waddr_mem_0_i == dec_rs2_i))  w_rs2_byp = wdata_mem_0_i;
    else if (we_int_0_i && (waddr_int_0_i == dec_rs2_i))  w_rs2_byp = wdata_int_0_i;
    else                                                  w_rs2_byp = wdata_int_1_i;
  end

  assign w_rs1_data  = (dec_rs1_i == c_X0) ? 32'd0 : (w_rs1_hit ? w_rs1_byp : w_rs1_rf);
  assign w_rs2_data  = (dec_rs2_i == c_X0) ? 32'd0 : (w_rs2_hit ? w_rs2_byp : w_rs2_rf);
  assign w_rs1_ready = !dec_rs1_use_i || (dec_rs1_i == c_X0) || !r_busy[dec_rs1_i] || w_rs1_hit;
  assign w_rs2_ready = !dec_rs2_use_i || (dec_rs2_i == c_X0) || !r_busy[dec_rs2_i] || w_rs2_hit;
`else
  // Writeback data is only needed for forwarding; fold it away here
  logic w_unused_wdata;
  assign w_unused_wdata = ^{wdata_jump_0_i, wdata_mem_0_i, wdata_int_0_i, wdata_int_1_i};

  assign w_rs1_data  = (dec_rs1_i == c_X0) ? 32'd0 : w_rs1_rf;
  assign w_rs2_data  = (dec_rs2_i == c_X0) ? 32'd0 : w_rs2_rf;
  assign w_rs1_ready = !dec_rs1_use_i || (dec_rs1_i == c_X0) || !r_busy[dec_rs1_i];
  assign w_rs2_ready = !dec_rs2_use_i || (dec_rs2_i == c_X0) || !r_busy[dec_rs2_i];
`endif

  // A pending writer of rd that is not retiring this cycle blocks a new writer
  assign w_waw       = dec_rd_we_i && (dec_rd_i != c_X0) && r_busy[dec_rd_i] && !w_wb_hit[dec_rd_i];
  assign w_slot_free = !r_iss_valid || iss_ready_i;
  assign dec_ready_o = !rst && !flush_i && w_slot_free && w_rs1_ready && w_rs2_ready && !w_waw;
  assign w_accept    = dec_valid_i && dec_ready_o;

  // Scoreboard next state: writeback clears, flush releases held rd, accept sets (set wins)
  always_comb begin
    w_busy_next = r_busy & ~w_wb_hit;
    if (flush_i && r_iss_valid && r_iss_rd_we) begin
      w_busy_next[r_iss_rd] = 1'b0;
    end
    if (w_accept && dec_rd_we_i && (dec_rd_i != c_X0)) begin
      w_busy_next[dec_rd_i] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // Issue slot: flush empties it, accept (re)loads it, issue alone empties it.
  // rd_we is dropped whenever the slot empties so a stale entry can never
  // release a busy bit later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss_valid    <= 1'b0;
      r_iss_rs1_data <= '0;
      r_iss_rs2_data <= '0;
      r_iss_rd       <= '0;
      r_iss_rd_we    <= 1'b0;
      r_iss_info     <= '0;
    end else if (flush_i) begin
      r_iss_valid <= 1'b0;
      r_iss_rd_we <= 1'b0;
    end else if (w_accept) begin
      r_iss_valid    <= 1'b1;
      r_iss_rs1_data <= w_rs1_data;
      r_iss_rs2_data <= w_rs2_data;
      r_iss_rd       <= dec_rd_i;
      r_iss_rd_we    <= dec_rd_we_i;
      r_iss_info     <= dec_info_i;
    end else if (r_iss_valid && iss_ready_i) begin
      r_iss_valid <= 1'b0;
      r_iss_rd_we <= 1'b0;
    end
  end

  assign iss_valid_o    = r_iss_valid;
  assign iss_rs1_data_o = r_iss_rs1_data;
  assign iss_rs2_data_o = r_iss_rs2_data;
  assign iss_rd_o       = r_iss_rd;
  assign iss_rd_we_o    = r_iss_rd_we;
  assign iss_info_o     = r_iss_info;
  assign busy_o         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_reg_read_issue.sv
`default_nettype none
// =====================================================================
// Module   : tb_reg_read_issue
// Summary  : Self-checking bench for reg_read_issue. The bench owns a
//            register-file model that drives reg_rdata_i, plus a
//            behavioural model of scoreboard and issue slot.
//            Follows REG_BYPASS_EN the same way the design does.
// Revision : 1.0 - initial release
// =====================================================================
module tb_reg_read_issue;

`ifdef REG_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1023:0] reg_rdata_i;
  logic          we_jump_0_i, we_mem_0_i, we_int_0_i, we_int_1_i;
  logic [4:0]    waddr_jump_0_i, waddr_mem_0_i, waddr_int_0_i, waddr_int_1_i;
  logic [31:0]   wdata_jump_0_i, wdata_mem_0_i, wdata_int_0_i, wdata_int_1_i;
  logic          dec_valid_i, dec_ready_o;
  logic [4:0]    dec_rs1_i, dec_rs2_i, dec_rd_i;
  logic          dec_rs1_use_i, dec_rs2_use_i, dec_rd_we_i;
  logic [31:0]   dec_info_i;
  logic          flush_i;
  logic          iss_valid_o, iss_ready_i;
  logic [31:0]   iss_rs1_data_o, iss_rs2_data_o, iss_info_o, busy_o;
  logic [4:0]    iss_rd_o;
  logic          iss_rd_we_o;

  // Model state
  logic [31:0] m_rf [32];
  logic [31:0] m_busy;
  logic        m_valid, m_rd_we;
  logic [4:0]  m_rd;
  logic [31:0] m_rs1d, m_rs2d, m_info;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Register file contents bus; x0 reads zero
  always_comb begin
    reg_rdata_i = '0;
    for (int i = 1; i < 32; i++) reg_rdata_i[i*32 +: 32] = m_rf[i];
  end

  reg_read_issue dut (
    .clk(clk), .rst(rst), .reg_rdata_i(reg_rdata_i),
    .we_jump_0_i(we_jump_0_i), .waddr_jump_0_i(waddr_jump_0_i), .wdata_jump_0_i(wdata_jump_0_i),
    .we_mem_0_i(we_mem_0_i),   .waddr_mem_0_i(waddr_mem_0_i),   .wdata_mem_0_i(wdata_mem_0_i),
    .we_int_0_i(we_int_0_i),   .waddr_int_0_i(waddr_int_0_i),   .wdata_int_0_i(wdata_int_0_i),
    .we_int_1_i(we_int_1_i),   .waddr_int_1_i(waddr_int_1_i),   .wdata_int_1_i(wdata_int_1_i),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i),
    .dec_rs1_use_i(dec_rs1_use_i), .dec_rs2_use_i(dec_rs2_use_i),
    .dec_rd_i(dec_rd_i), .dec_rd_we_i(dec_rd_we_i), .dec_info_i(dec_info_i),
    .flush_i(flush_i), .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
    .iss_rs1_data_o(iss_rs1_data_o), .iss_rs2_data_o(iss_rs2_data_o),
    .iss_rd_o(iss_rd_o), .iss_rd_we_o(iss_rd_we_o), .iss_info_o(iss_info_o),
    .busy_o(busy_o)
  );

  // ---------------- reference model ----------------
  function automatic bit m_hit(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    return (we_jump_0_i && waddr_jump_0_i == r) || (we_mem_0_i && waddr_mem_0_i == r) ||
           (we_int_0_i && waddr_int_0_i == r)   || (we_int_1_i && waddr_int_1_i == r);
  endfunction

  function automatic logic [31:0] m_wbdata(input logic [4:0] r);
    if (we_jump_0_i && waddr_jump_0_i == r) return wdata_jump_0_i;
    if (we_mem_0_i  && waddr_mem_0_i  == r) return wdata_mem_0_i;
    if (we_int_0_i  && waddr_int_0_i  == r) return wdata_int_0_i;
    return wdata_int_1_i;
  endfunction

  function automatic bit m_src_ok(input logic use_src, input logic [4:0] rs);
    if (!use_src || rs == 5'd0) return 1'b1;
    return !m_busy[rs] || (BYPASS && m_hit(rs));
  endfunction

  function automatic bit m_ready();
    bit waw;
    waw = dec_rd_we_i && (dec_rd_i != 5'd0) && m_busy[dec_rd_i] && !m_hit(dec_rd_i);
    return !rst && !flush_i && (!m_valid || iss_ready_i) &&
           m_src_ok(dec_rs1_use_i, dec_rs1_i) && m_src_ok(dec_rs2_use_i, dec_rs2_i) && !waw;
  endfunction

  function automatic logic [31:0] m_operand(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (BYPASS && m_hit(rs)) return m_wbdata(rs);
    return m_rf[rs];
  endfunction

  // Advance one clock: predict from current inputs, clock the DUT, commit
  task automatic tick();
    bit          acc;
    logic [31:0] nb, n1, n2, ni;
    logic        nv, nwe;
    logic [4:0]  nrd;
    bit          wv [4];
    logic [4:0]  wa [4];
    logic [31:0] wd [4];
    acc = dec_valid_i && m_ready();
    nv = m_valid; nwe = m_rd_we; nrd = m_rd; n1 = m_rs1d; n2 = m_rs2d; ni = m_info; nb = m_busy;
    if (rst) begin
      nv = 0; nwe = 0; nrd = 0; n1 = 0; n2 = 0; ni = 0; nb = 0;
    end else begin
      for (int r = 1; r < 32; r++) if (m_hit(5'(r))) nb[r] = 1'b0;
      if (flush_i) begin
        if (m_valid && m_rd_we) nb[m_rd] = 1'b0;
        nv = 0;
      end else if (acc) begin
        nv = 1; n1 = m_operand(dec_rs1_i); n2 = m_operand(dec_rs2_i);
        nrd = dec_rd_i; nwe = dec_rd_we_i; ni = dec_info_i;
        if (dec_rd_we_i && dec_rd_i != 5'd0) nb[dec_rd_i] = 1'b1;
      end else if (m_valid && iss_ready_i) begin
        nv = 0;
      end
    end
    nb[0] = 1'b0;
    // lowest priority first so the highest-priority port's data lands last
    wv = '{we_int_1_i, we_int_0_i, we_mem_0_i, we_jump_0_i};
    wa = '{waddr_int_1_i, waddr_int_0_i, waddr_mem_0_i, waddr_jump_0_i};
    wd = '{wdata_int_1_i, wdata_int_0_i, wdata_mem_0_i, wdata_jump_0_i};
    @(posedge clk);
    #1;
    m_valid = nv; m_rd_we = nwe; m_rd = nrd; m_rs1d = n1; m_rs2d = n2; m_info = ni; m_busy = nb;
    for (int p = 0; p < 4; p++) if (wv[p] && wa[p] != 5'd0) m_rf[wa[p]] = wd[p];
  endtask

  task automatic drive_idle();
    rst = 0; flush_i = 0; iss_ready_i = 1;
    dec_valid_i = 0; dec_rs1_i = 0; dec_rs2_i = 0; dec_rs1_use_i = 0; dec_rs2_use_i = 0;
    dec_rd_i = 0; dec_rd_we_i = 0; dec_info_i = 0;
    we_jump_0_i = 0; waddr_jump_0_i = 0; wdata_jump_0_i = 0;
    we_mem_0_i = 0;  waddr_mem_0_i = 0;  wdata_mem_0_i = 0;
    we_int_0_i = 0;  waddr_int_0_i = 0;  wdata_int_0_i = 0;
    we_int_1_i = 0;  waddr_int_1_i = 0;  wdata_int_1_i = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    rst = 1; dec_valid_i = 1;
    #1;
    n_total++; if (dec_ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", dec_ready_o); else n_pass++;
    tick(); tick();
    n_total++;
    if ({iss_valid_o, iss_rs1_data_o, iss_rs2_data_o, iss_rd_o, iss_rd_we_o, iss_info_o} !== 103'd0)
      $display("FAIL reset_slot: got v=%b d1=%h d2=%h rd=%0d we=%b info=%h want all 0",
               iss_valid_o, iss_rs1_data_o, iss_rs2_data_o, iss_rd_o, iss_rd_we_o, iss_info_o);
    else n_pass++;
    n_total++; if (busy_o !== 32'd0) $display("FAIL reset_busy: got %h want 0", busy_o); else n_pass++;
    drive_idle();
    #1;
    n_total++; if (dec_ready_o !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", dec_ready_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive_idle();
    for (int i = 0; i < 5; i++) begin
      dec_valid_i = 1; dec_rs1_i = 1; dec_rs2_i = 2; dec_rs1_use_i = 1; dec_rs2_use_i = 1;
      dec_info_i = 32'hB000 + i;
      #1;
      n_total++; if (dec_ready_o !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", i, dec_ready_o); else n_pass++;
      tick();
      n_total++;
      if ({iss_valid_o, iss_rs1_data_o, iss_rs2_data_o, iss_info_o, busy_o} !==
          {1'b1, 32'h11, 32'h22, 32'hB000 + 32'(i), 32'd0})
        $display("FAIL b2b_issue[%0d]: got v=%b d1=%h d2=%h info=%h busy=%h want 1/11/22/%h/0",
                 i, iss_valid_o, iss_rs1_data_o, iss_rs2_data_o, iss_info_o, busy_o, 32'hB000 + i);
      else n_pass++;
    end
    drive_idle(); tick();
  endtask

  // Producer writes rd; consumer reads it; writeback arrives on one or two ports
  task automatic test_dependency(input string name, input logic [4:0] r, input bit use_rs2,
                                 input bit two_ports, input logic [31:0] want);
    drive_idle(); tick();
    dec_valid_i = 1; dec_rd_i = r; dec_rd_we_i = 1; dec_info_i = 32'hA0;
    tick();
    n_total++; if (busy_o[r] !== 1'b1) $display("FAIL %s_busy_set: got %b want 1", name, busy_o[r]); else n_pass++;
    dec_rd_we_i = 0; dec_rd_i = 0; dec_info_i = 32'hC0;
    if (use_rs2) begin dec_rs2_i = r; dec_rs2_use_i = 1; end
    else         begin dec_rs1_i = r; dec_rs1_use_i = 1; end
    #1;
    n_total++; if (dec_ready_o !== 1'b0) $display("FAIL %s_stall: got %b want 0", name, dec_ready_o); else n_pass++;
    tick();
    if (two_ports) begin
      we_jump_0_i = 1; waddr_jump_0_i = r; wdata_jump_0_i = want;
      we_int_1_i  = 1; waddr_int_1_i  = r; wdata_int_1_i  = 32'h2222_7777;
    end else begin
      we_int_0_i = 1; waddr_int_0_i = r; wdata_int_0_i = want;
    end
    #1;
    n_total++; if (dec_ready_o !== BYPASS) $display("FAIL %s_wb_ready: got %b want %b", name, dec_ready_o, BYPASS); else n_pass++;
    tick();
    we_jump_0_i = 0; we_int_0_i = 0; we_int_1_i = 0;
    n_total++;
    if ({iss_valid_o, busy_o[r]} !== {BYPASS, 1'b0})
      $display("FAIL %s_wb_cycle: got v=%b busy=%b want v=%b busy=0", name, iss_valid_o, busy_o[r], BYPASS);
    else n_pass++;
    // re-present only if not yet taken; hold the slot so it can be inspected
    dec_valid_i = !iss_valid_o; iss_ready_i = 0;
    #1;
    n_total++; if (dec_ready_o !== m_ready()) $display("FAIL %s_late_ready: got %b want %b", name, dec_ready_o, m_ready()); else n_pass++;
    tick();
    n_total++;
    if ({iss_valid_o, (use_rs2 ? iss_rs2_data_o : iss_rs1_data_o), iss_info_o} !== {1'b1, want, 32'hC0})
      $display("FAIL %s_operand: got v=%b d=%h info=%h want 1/%h/c0", name, iss_valid_o,
               use_rs2 ? iss_rs2_data_o : iss_rs1_data_o, iss_info_o, want);
    else n_pass++;
    drive_idle(); tick();
  endtask

  task automatic test_x0();
    drive_idle();
    dec_valid_i = 1; dec_rs1_i = 0; dec_rs1_use_i = 1; dec_rd_i = 0; dec_rd_we_i = 1; dec_info_i = 32'h0;
    #1;
    n_total++; if (dec_ready_o !== 1'b1) $display("FAIL x0_ready: got %b want 1", dec_ready_o); else n_pass++;
    tick();
    n_total++;
    if ({iss_valid_o, iss_rs1_data_o, busy_o} !== {1'b1, 32'd0, 32'd0})
      $display("FAIL x0_issue: got v=%b d1=%h busy=%h want 1/0/0", iss_valid_o, iss_rs1_data_o, busy_o);
    else n_pass++;
    drive_idle(); tick();
  endtask

  task automatic test_backpressure();
    drive_idle();
    iss_ready_i = 0;
    dec_valid_i = 1; dec_rs1_i = 1; dec_rs2_i = 2; dec_rs1_use_i = 1; dec_rs2_use_i = 1; dec_info_i = 32'hAAAA;
    tick();
    dec_info_i = 32'hBBBB; dec_rs1_i = 3;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_total++; if (dec_ready_o !== 1'b0) $display("FAIL bp_ready[%0d]: got %b want 0", i, dec_ready_o); else n_pass++;
      tick();
      n_total++;
      if ({iss_valid_o, iss_info_o, iss_rs1_data_o} !== {1'b1, 32'hAAAA, 32'h11})
        $display("FAIL bp_hold[%0d]: got v=%b info=%h d1=%h want 1/aaaa/11", i, iss_valid_o, iss_info_o, iss_rs1_data_o);
      else n_pass++;
    end
    iss_ready_i = 1;
    #1;
    n_total++; if (dec_ready_o !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", dec_ready_o); else n_pass++;
    tick();
    n_total++;
    if ({iss_valid_o, iss_info_o, iss_rs1_data_o} !== {1'b1, 32'hBBBB, m_rf[3]})
      $display("FAIL bp_reload: got v=%b info=%h d1=%h want 1/bbbb/%h", iss_valid_o, iss_info_o, iss_rs1_data_o, m_rf[3]);
    else n_pass++;
    drive_idle(); tick();
  endtask

  task automatic test_flush();
    drive_idle();
    iss_ready_i = 0;
    dec_valid_i = 1; dec_rd_i = 9; dec_rd_we_i = 1; dec_info_i = 32'h99;
    tick();
    n_total++;
    if ({iss_valid_o, iss_rd_o, busy_o[9]} !== {1'b1, 5'd9, 1'b1})
      $display("FAIL flush_setup: got v=%b rd=%0d busy9=%b want 1/9/1", iss_valid_o, iss_rd_o, busy_o[9]);
    else n_pass++;
    flush_i = 1; iss_ready_i = 1; dec_rd_i = 4; dec_info_i = 32'hF0;
    #1;
    n_total++; if (dec_ready_o !== 1'b0) $display("FAIL flush_ready: got %b want 0", dec_ready_o); else n_pass++;
    tick();
    n_total++;
    if ({iss_valid_o, busy_o} !== {1'b0, 32'd0})
      $display("FAIL flush_result: got v=%b busy=%h want 0/0", iss_valid_o, busy_o);
    else n_pass++;
    drive_idle(); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 63) == 0);
      flush_i     = ($urandom_range(0, 19) == 0);
      iss_ready_i = ($urandom_range(0, 3) != 0);
      dec_valid_i = ($urandom_range(0, 3) != 0);
      dec_rs1_i = 5'($urandom_range(0, 7)); dec_rs1_use_i = $urandom_range(0, 1);
      dec_rs2_i = 5'($urandom_range(0, 7)); dec_rs2_use_i = $urandom_range(0, 1);
      dec_rd_i  = 5'($urandom_range(0, 7)); dec_rd_we_i   = $urandom_range(0, 1);
      dec_info_i = $urandom();
      we_jump_0_i = ($urandom_range(0, 3) == 0); waddr_jump_0_i = 5'($urandom_range(0, 7)); wdata_jump_0_i = $urandom();
      we_mem_0_i  = ($urandom_range(0, 3) == 0); waddr_mem_0_i  = 5'($urandom_range(0, 7)); wdata_mem_0_i  = $urandom();
      we_int_0_i  = ($urandom_range(0, 3) == 0); waddr_int_0_i  = 5'($urandom_range(0, 7)); wdata_int_0_i  = $urandom();
      we_int_1_i  = ($urandom_range(0, 3) == 0); waddr_int_1_i  = 5'($urandom_range(0, 7)); wdata_int_1_i  = $urandom();
      #1;
      n_total++;
      if (dec_ready_o !== m_ready()) $display("FAIL rnd_ready[%0d]: got %b want %b", c, dec_ready_o, m_ready());
      else n_pass++;
      tick();
      n_total++;
      if ({iss_valid_o, busy_o} !== {m_valid, m_busy})
        $display("FAIL rnd_state[%0d]: got v=%b busy=%h want v=%b busy=%h", c, iss_valid_o, busy_o, m_valid, m_busy);
      else n_pass++;
      if (m_valid) begin
        n_total++;
        if ({iss_rs1_data_o, iss_rs2_data_o, iss_rd_o, iss_rd_we_o, iss_info_o} !==
            {m_rs1d, m_rs2d, m_rd, m_rd_we, m_info})
          $display("FAIL rnd_slot[%0d]: got %h/%h/%0d/%b/%h want %h/%h/%0d/%b/%h", c,
                   iss_rs1_data_o, iss_rs2_data_o, iss_rd_o, iss_rd_we_o, iss_info_o,
                   m_rs1d, m_rs2d, m_rd, m_rd_we, m_info);
        else n_pass++;
      end
    end
    drive_idle(); tick();
  endtask

  initial begin
    m_busy = '0; m_valid = 0; m_rd_we = 0; m_rd = 0; m_rs1d = 0; m_rs2d = 0; m_info = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = (i == 0) ? 32'd0 : $urandom();
    m_rf[1] = 32'h11;
    m_rf[2] = 32'h22;
    test_reset();
    test_back_to_back();
    test_dependency("raw", 5'd5, 1'b0, 1'b0, 32'h0000_ABCD);
    test_dependency("simul", 5'd7, 1'b1, 1'b1, 32'h1111_7777);
    test_x0();
    test_backpressure();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
